// File: rtl/uart_rx_sram_sequencer_pkg.sv
// Shared types for the UART receive to SRAM capture sequencer.
// Holds the FSM state encoding and the saturating error-counter helper.
package uart_rx_sram_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BYTE,
      S_UNLOAD_WAIT,
      S_WRITE,
      S_DONE
   } UART_SRAM_seq_state_type;

   localparam int ADDR_W = 18;
   localparam int WORD_W = 16;
   localparam int CNT_W  = 8;

   // Error counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == {CNT_W{1'b1}}) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/uart_rx_sram_sequencer.sv
// Unloads bytes from the UART receiver, packs pairs into 16-bit words and writes
// them to consecutive SRAM addresses, counting receiver errors along the way.
module uart_rx_sram_sequencer
   import uart_rx_sram_sequencer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] NUM_WORDS = 18'd4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 18'd0
) (
   input  logic              Clock_50,
   input  logic              Resetn,
   input  logic              Start,
   output logic              Busy,
   output logic              Done,
   output logic              RX_enable,
   output logic              RX_unload,
   input  logic [7:0]        RX_data,
   input  logic              RX_empty,
   input  logic              RX_overrun,
   input  logic              RX_frame_error,
   output logic [ADDR_W-1:0] SRAM_address,
   output logic [WORD_W-1:0] SRAM_write_data,
   output logic              SRAM_we_n,
   output logic [CNT_W-1:0]  Frame_error_count,
   output logic [CNT_W-1:0]  Overrun_count
);

   UART_SRAM_seq_state_type state, state_n;

   logic              byte_sel, byte_sel_n;
   logic [ADDR_W-1:0] word_count, word_count_n;
   logic              frame_error_prev, overrun_prev;

   logic              busy_n, done_n, rx_enable_n, rx_unload_n, sram_we_n_n;
   logic [ADDR_W-1:0] sram_address_n;
   logic [WORD_W-1:0] sram_write_data_n;
   logic [CNT_W-1:0]  frame_error_count_n, overrun_count_n;

   // NOTE: every signal gets a default before the case statement, so no path
   // through this block can leave a value unassigned and infer a latch.
   always_comb begin
      state_n             = state;
      byte_sel_n          = byte_sel;
      word_count_n        = word_count;
      sram_address_n      = SRAM_address;
      sram_write_data_n   = SRAM_write_data;
      frame_error_count_n = Frame_error_count;
      overrun_count_n     = Overrun_count;
      rx_unload_n         = 1'b0;

      if (state != S_IDLE) begin
         if (RX_frame_error && !frame_error_prev)
            frame_error_count_n = sat_inc(Frame_error_count);
         if (RX_overrun && !overrun_prev)
            overrun_count_n = sat_inc(Overrun_count);
      end

      case (state)
         S_IDLE: begin
            if (Start) begin
               frame_error_count_n = '0;
               overrun_count_n     = '0;
               word_count_n        = '0;
               byte_sel_n          = 1'b0;
               sram_address_n      = BASE_ADDR;
               state_n             = S_WAIT_BYTE;
            end
         end
         S_WAIT_BYTE: begin
            if (!RX_empty) begin
               rx_unload_n = 1'b1;
               if (!byte_sel) begin
                  sram_write_data_n[15:8] = RX_data;
                  byte_sel_n              = 1'b1;
                  state_n                 = S_UNLOAD_WAIT;
               end else begin
                  sram_write_data_n[7:0] = RX_data;
                  state_n                = S_WRITE;
               end
            end
         end
         // The unload pulse is live during this state, so Empty is still stale here.
         S_UNLOAD_WAIT: state_n = S_WAIT_BYTE;
         S_WRITE: begin
            sram_address_n = SRAM_address + 18'd1;
            word_count_n   = word_count + 18'd1;
            byte_sel_n     = 1'b0;
            state_n        = (word_count == NUM_WORDS - 18'd1) ? S_DONE : S_WAIT_BYTE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      busy_n      = (state_n != S_IDLE);
      done_n      = (state_n == S_DONE);
      sram_we_n_n = (state_n != S_WRITE);
      rx_enable_n = (state_n == S_WAIT_BYTE) || (state_n == S_UNLOAD_WAIT) ||
                    (state_n == S_WRITE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state             <= S_IDLE;
         byte_sel          <= 1'b0;
         word_count        <= '0;
         frame_error_prev  <= 1'b0;
         overrun_prev      <= 1'b0;
         Busy              <= 1'b0;
         Done              <= 1'b0;
         RX_enable         <= 1'b0;
         RX_unload         <= 1'b0;
         SRAM_we_n         <= 1'b1;
         SRAM_address      <= BASE_ADDR;
         SRAM_write_data   <= '0;
         Frame_error_count <= '0;
         Overrun_count     <= '0;
      end else begin
         state             <= state_n;
         byte_sel          <= byte_sel_n;
         word_count        <= word_count_n;
         frame_error_prev  <= RX_frame_error;
         overrun_prev      <= RX_overrun;
         Busy              <= busy_n;
         Done              <= done_n;
         RX_enable         <= rx_enable_n;
         RX_unload         <= rx_unload_n;
         SRAM_we_n         <= sram_we_n_n;
         SRAM_address      <= sram_address_n;
         SRAM_write_data   <= sram_write_data_n;
         Frame_error_count <= frame_error_count_n;
         Overrun_count     <= overrun_count_n;
      end
   end

endmodule

// File: tb/tb_uart_rx_sram_sequencer.sv
// Bench for uart_rx_sram_sequencer: a stub receiver feeds bytes and error flags
// to one of two instances (base 0, base 3FFFF); SRAM writes are scoreboarded.
module tb_uart_rx_sram_sequencer;

   localparam int EV_BYTE    = 0;
   localparam int EV_FRAME   = 1;
   localparam int EV_OVERRUN = 2;

   logic        Clock_50 = 1'b0;
   logic        Resetn;
   logic        start;
   logic        sel;
   logic [7:0]  rx_data;
   logic        rx_empty, rx_overrun, rx_frame_error;

   logic        a_busy, a_done, a_enable, a_unload, a_we_n;
   logic [17:0] a_addr;
   logic [15:0] a_data;
   logic [7:0]  a_fe, a_ov;
   logic        b_busy, b_done, b_enable, b_unload, b_we_n;
   logic [17:0] b_addr;
   logic [15:0] b_data;
   logic [7:0]  b_fe, b_ov;

   logic start_a, start_b, empty_a, empty_b;
   assign start_a = start & ~sel;
   assign start_b = start & sel;
   assign empty_a = rx_empty | sel;
   assign empty_b = rx_empty | ~sel;

   uart_rx_sram_sequencer #(.NUM_WORDS(18'd2), .BASE_ADDR(18'd0)) dut_a (
      .Clock_50(Clock_50), .Resetn(Resetn), .Start(start_a), .Busy(a_busy), .Done(a_done),
      .RX_enable(a_enable), .RX_unload(a_unload), .RX_data(rx_data), .RX_empty(empty_a),
      .RX_overrun(rx_overrun), .RX_frame_error(rx_frame_error), .SRAM_address(a_addr),
      .SRAM_write_data(a_data), .SRAM_we_n(a_we_n), .Frame_error_count(a_fe),
      .Overrun_count(a_ov));

   uart_rx_sram_sequencer #(.NUM_WORDS(18'd2), .BASE_ADDR(18'h3FFFF)) dut_b (
      .Clock_50(Clock_50), .Resetn(Resetn), .Start(start_b), .Busy(b_busy), .Done(b_done),
      .RX_enable(b_enable), .RX_unload(b_unload), .RX_data(rx_data), .RX_empty(empty_b),
      .RX_overrun(rx_overrun), .RX_frame_error(rx_frame_error), .SRAM_address(b_addr),
      .SRAM_write_data(b_data), .SRAM_we_n(b_we_n), .Frame_error_count(b_fe),
      .Overrun_count(b_ov));

   always #10 Clock_50 = ~Clock_50;

   logic        m_busy, m_done, m_enable, m_unload, m_we_n;
   logic [17:0] m_addr;
   logic [15:0] m_data;
   logic [7:0]  m_fe, m_ov;
   assign m_busy   = sel ? b_busy   : a_busy;
   assign m_done   = sel ? b_done   : a_done;
   assign m_enable = sel ? b_enable : a_enable;
   assign m_unload = sel ? b_unload : a_unload;
   assign m_we_n   = sel ? b_we_n   : a_we_n;
   assign m_addr   = sel ? b_addr   : a_addr;
   assign m_data   = sel ? b_data   : a_data;
   assign m_fe     = sel ? b_fe     : a_fe;
   assign m_ov     = sel ? b_ov     : a_ov;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [33:0] wr_q[$];
   int          done_cnt, unload_cnt;
   logic [7:0]  ev_b[$];
   int          ev_k[$];

   always @(negedge Clock_50) begin
      if (!m_we_n) wr_q.push_back({m_addr, m_data});
      if (m_done) done_cnt++;
      if (m_unload) unload_cnt++;
   end

   typedef struct {
      string       name;
      logic        sel;
      int          n;
      logic [47:0] bytes;
      logic [11:0] kinds;
      logic        mid_start;
      logic [35:0] addrs;
      logic [31:0] words;
      logic [7:0]  fe;
      logic [7:0]  ov;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic begin_xfer(input logic which);
      @(negedge Clock_50);
      sel = which;
      wr_q.delete();
      done_cnt   = 0;
      unload_cnt = 0;
   endtask

   task automatic start_pulse();
      @(negedge Clock_50) start = 1'b1;
      @(negedge Clock_50) start = 1'b0;
   endtask

   // Stub receiver: presents a byte and raises Empty on the edge that ends the unload cycle.
   task automatic present_byte(input logic [7:0] b, input logic ovr);
      bit got = 0;
      @(negedge Clock_50);
      rx_data    = b;
      rx_empty   = 1'b0;
      rx_overrun = ovr;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock_50);
         if (m_unload) begin
            got = 1;
            break;
         end
      end
      check("unload_seen", 32'(got), 32'd1);
      @(posedge Clock_50);
      #1;
      rx_empty   = 1'b1;
      rx_overrun = 1'b0;
   endtask

   task automatic frame_err();
      @(negedge Clock_50) rx_frame_error = 1'b1;
      repeat (2) @(negedge Clock_50);
      rx_frame_error = 1'b0;
   endtask

   task automatic run_events(input logic mid_start);
      for (int e = 0; e < ev_k.size(); e++) begin
         repeat ($urandom_range(0, 2)) @(negedge Clock_50);
         if (ev_k[e] == EV_FRAME) frame_err();
         else present_byte(ev_b[e], ev_k[e] == EV_OVERRUN);
         if (mid_start && e == 0) start_pulse();
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         if (done_cnt > 0) break;
         @(negedge Clock_50);
      end
      repeat (3) @(negedge Clock_50);
   endtask

   task automatic verify(input string name, input logic [17:0] a0, input logic [17:0] a1,
                         input logic [15:0] w0, input logic [15:0] w1, input logic [7:0] fe,
                         input logic [7:0] ov, input int unloads);
      check({name, "_nwrites"}, 32'(wr_q.size()), 32'd2);
      if (wr_q.size() > 0) check({name, "_w0"}, 32'(wr_q[0]), 32'({a0, w0}));
      if (wr_q.size() > 1) check({name, "_w1"}, 32'(wr_q[1]), 32'({a1, w1}));
      check({name, "_done"}, 32'(done_cnt), 32'd1);
      check({name, "_unloads"}, 32'(unload_cnt), 32'(unloads));
      check({name, "_fe"}, 32'(m_fe), 32'(fe));
      check({name, "_ov"}, 32'(m_ov), 32'(ov));
      check({name, "_idle"}, {30'd0, m_busy, m_enable}, 32'd0);
   endtask

   // Reference model: good bytes pair up in arrival order; frame-errored events vanish.
   task automatic model_verify(input string name);
      logic [7:0]  goods[$];
      int          nfe = 0;
      int          nov = 0;
      logic [17:0] base;
      for (int e = 0; e < ev_k.size(); e++) begin
         if (ev_k[e] == EV_FRAME) nfe++;
         else goods.push_back(ev_b[e]);
         if (ev_k[e] == EV_OVERRUN) nov++;
      end
      base = sel ? 18'h3FFFF : 18'h0;
      verify(name, base, 18'((int'(base) + 1) % 262144), {goods[0], goods[1]},
             {goods[2], goods[3]}, 8'((nfe > 255) ? 255 : nfe), 8'((nov > 255) ? 255 : nov),
             goods.size());
   endtask

   function automatic vec_t mk(input string name, input logic s, input int n,
                               input logic [47:0] bytes, input logic [11:0] kinds,
                               input logic mid, input logic [35:0] addrs,
                               input logic [31:0] words, input logic [7:0] fe,
                               input logic [7:0] ov);
      vec_t v;
      v.name = name; v.sel = s; v.n = n; v.bytes = bytes; v.kinds = kinds;
      v.mid_start = mid; v.addrs = addrs; v.words = words; v.fe = fe; v.ov = ov;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nunl;
      bit seen;
      vecs[0] = mk("basic",    0, 4, 48'h12345678_0000, 12'h000, 0, {18'h0, 18'h1},     32'h1234_5678, 0, 0);
      vecs[1] = mk("second",   0, 4, 48'hABCDEF01_0000, 12'h000, 0, {18'h0, 18'h1},     32'hABCD_EF01, 0, 0);
      vecs[2] = mk("frameskip",0, 5, 48'h11002233_4400, 12'h100, 0, {18'h0, 18'h1},     32'h1122_3344, 1, 0);
      vecs[3] = mk("overrun",  0, 4, 48'h99887766_0000, 12'h800, 0, {18'h0, 18'h1},     32'h9988_7766, 0, 1);
      vecs[4] = mk("wrapstart",1, 4, 48'hA1B2C3D4_0000, 12'h000, 1, {18'h3FFFF, 18'h0}, 32'hA1B2_C3D4, 0, 0);

      Resetn = 1'b0; start = 1'b0; sel = 1'b0; rx_data = 8'h00;
      rx_empty = 1'b1; rx_overrun = 1'b0; rx_frame_error = 1'b0;
      repeat (3) @(negedge Clock_50);
      Resetn = 1'b1;
      @(negedge Clock_50);
      check("rst_ctrl", {27'd0, a_busy, a_done, a_enable, a_unload, a_we_n}, 32'd1);
      check("rst_addr_a", 32'(a_addr), 32'h0);
      check("rst_addr_b", 32'(b_addr), 32'h3FFFF);
      check("rst_data", 32'(a_data), 32'h0);
      check("rst_counts", {16'd0, a_fe, a_ov}, 32'd0);

      for (int v = 0; v < 5; v++) begin
         begin_xfer(vecs[v].sel);
         ev_b.delete();
         ev_k.delete();
         nunl = 0;
         for (int e = 0; e < vecs[v].n; e++) begin
            ev_b.push_back(vecs[v].bytes[47-8*e -: 8]);
            ev_k.push_back(int'(vecs[v].kinds[11-2*e -: 2]));
            if (ev_k[e] != EV_FRAME) nunl++;
         end
         start_pulse();
         run_events(vecs[v].mid_start);
         wait_done();
         verify(vecs[v].name, vecs[v].addrs[35:18], vecs[v].addrs[17:0], vecs[v].words[31:16],
                vecs[v].words[15:0], vecs[v].fe, vecs[v].ov, nunl);
      end

      // A lone byte is unloaded once and produces no write until its partner arrives.
      begin_xfer(0);
      start_pulse();
      present_byte(8'hAB, 0);
      repeat (10) @(negedge Clock_50);
      check("single_unloads", 32'(unload_cnt), 32'd1);
      check("single_nowrite", 32'(wr_q.size()), 32'd0);
      check("single_busy", 32'(a_busy), 32'd1);
      present_byte(8'hCD, 0);
      repeat (3) @(negedge Clock_50);
      check("pair_nwrites", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) check("pair_word", 32'(wr_q[0]), 32'({18'h0, 16'hABCD}));
      present_byte(8'h01, 0);
      present_byte(8'h02, 0);
      wait_done();
      check("pair_done", 32'(done_cnt), 32'd1);

      // Reset after three bytes: the next transfer restarts at the base with new data only.
      begin_xfer(0);
      start_pulse();
      present_byte(8'hDE, 0);
      present_byte(8'hAD, 0);
      present_byte(8'hBE, 0);
      @(negedge Clock_50) Resetn = 1'b0;
      #1;
      check("midrst_state", {27'd0, a_busy, a_done, a_enable, a_unload, a_we_n}, 32'd1);
      check("midrst_addr", 32'(a_addr), 32'h0);
      @(negedge Clock_50) Resetn = 1'b1;
      begin_xfer(0);
      ev_b = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
      ev_k = '{EV_BYTE, EV_BYTE, EV_BYTE, EV_BYTE};
      start_pulse();
      run_events(0);
      wait_done();
      verify("after_reset", 18'h0, 18'h1, 16'h5A5B, 16'h5C5D, 0, 0, 4);

      // Frame error count saturates at FF and holds after Done.
      begin_xfer(0);
      start_pulse();
      for (int i = 0; i < 260; i++) frame_err();
      ev_b = '{8'h01, 8'h02, 8'h03, 8'h04};
      ev_k = '{EV_BYTE, EV_BYTE, EV_BYTE, EV_BYTE};
      run_events(0);
      wait_done();
      verify("saturate", 18'h0, 18'h1, 16'h0102, 16'h0304, 8'hFF, 0, 4);

      // Next Start clears counters; a Start coinciding with Done is ignored.
      begin_xfer(0);
      start_pulse();
      check("start_clears_fe", 32'(a_fe), 32'd0);
      for (int i = 0; i < 4; i++) present_byte(8'(8'h40 + i), 0);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clock_50);
         if (m_done) begin
            seen = 1;
            break;
         end
      end
      check("done_for_start", 32'(seen), 32'd1);
      start = 1'b1;
      @(negedge Clock_50) start = 1'b0;
      check("start_at_done_ignored", 32'(a_busy), 32'd0);
      repeat (3) @(negedge Clock_50);
      check("done_once", 32'(done_cnt), 32'd1);

      // Randomized transfers against the reference model.
      for (int t = 0; t < 12; t++) begin
         begin_xfer(1'($urandom_range(0, 1)));
         ev_b.delete();
         ev_k.delete();
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               ev_b.push_back(8'h00);
               ev_k.push_back(EV_FRAME);
            end
            ev_b.push_back(8'($urandom));
            ev_k.push_back(($urandom_range(0, 4) == 0) ? EV_OVERRUN : EV_BYTE);
         end
         start_pulse();
         run_events(1'($urandom_range(0, 1)));
         wait_done();
         model_verify($sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_sram_sequencer.md
Name: uart_rx_sram_sequencer

Overview:
Sequences the UART receive controller to capture a fixed-length byte stream and store it in the external 16-bit SRAM. It enables the receiver and unloads each byte as soon as one is available. It packs byte pairs into 16-bit words and issues one SRAM write per word. It also counts frame and overrun errors and signals completion to the top-level FSM.

Parameters:
NUM_WORDS, 18'd4, number of 16-bit words per transfer; 2*NUM_WORDS bytes are captured; legal range 1..2^18-1.
BASE_ADDR, 18'd0, SRAM address of the first word written.

Ports:
Clock_50  in  1  system clock, 50 MHz
Resetn  in  1  asynchronous, active-low reset
Start  in  1  one-cycle pulse that begins a transfer; ignored unless in S_IDLE
Busy  out  1  high in every state except S_IDLE
Done  out  1  one-cycle pulse after the last SRAM write
RX_enable  out  1  drives the receiver Enable input
RX_unload  out  1  drives the receiver Unload_data input; one-cycle pulse
RX_data  in  8  receiver data byte
RX_empty  in  1  receiver Empty flag
RX_overrun  in  1  receiver Overrun flag
RX_frame_error  in  1  receiver Frame_error flag
SRAM_address  out  18  SRAM word address
SRAM_write_data  out  16  SRAM write data
SRAM_we_n  out  1  SRAM write enable, active-low
Frame_error_count  out  8  saturating count of frame errors in the current transfer
Overrun_count  out  8  saturating count of overruns in the current transfer

Behaviour:
- Reset values: Busy=0, Done=0, RX_enable=0, RX_unload=0, SRAM_we_n=1, SRAM_address=BASE_ADDR, SRAM_write_data=0, both counters=0, byte_sel=0, word_count=0, state=S_IDLE.
- Reset mid-transfer: return to S_IDLE immediately and discard the partial word. A later Start always begins at BASE_ADDR.
- All outputs are registered.
- S_IDLE: RX_enable=0. On Start:
  - clear both counters, word_count and byte_sel;
  - set SRAM_address=BASE_ADDR;
  - go to S_WAIT_BYTE.
- S_WAIT_BYTE: RX_enable=1. When RX_empty==0:
  - assert RX_unload for exactly one cycle;
  - capture RX_data in the same cycle;
  - byte_sel==0: store the byte in the high half (data[15:8]), set byte_sel=1, go to S_UNLOAD_WAIT;
  - byte_sel==1: store the byte in the low half (data[7:0]), go to S_WRITE.
- S_UNLOAD_WAIT: one cycle that absorbs the receiver's Empty update latency, so the same byte is never taken twice. Then go to S_WAIT_BYTE.
- S_WRITE: SRAM_we_n=0 for exactly one cycle with SRAM_address and SRAM_write_data stable. Next cycle:
  - SRAM_we_n=1, address+1, word_count+1, byte_sel=0;
  - if word_count==NUM_WORDS-1, go to S_DONE; otherwise go to S_WAIT_BYTE.
- S_DONE: Done=1 for one cycle, RX_enable=0, return to S_IDLE. The counters hold their values until the next Start.
- Latency: the second byte is unloaded in cycle N, the SRAM write occurs in cycle N+1, and the next byte can be accepted from cycle N+2. RX_enable stays high across S_UNLOAD_WAIT and S_WRITE, so reception is never interrupted.
- Error counting: increment on the 0->1 transition of each registered flag (RX_frame_error, RX_overrun), only while Busy. Counters saturate at 8'hFF.
  - A frame-errored byte is never presented by the receiver (Empty stays 1), so it is skipped and not stored.
  - An overrun byte is stored normally.
- Address wrap: SRAM_address wraps modulo 2^18 with no error.
- Start asserted while Busy: ignored, with no effect on any state.
- A Start in the same cycle as Done is ignored, because the state is still S_DONE.

Decomposition:
- Shared package (define_state.h): enum UART_SRAM_seq_state_type with S_IDLE, S_WAIT_BYTE, S_UNLOAD_WAIT, S_WRITE, S_DONE.
- Single module with no sub-modules. The two edge-detect-and-saturating-counter pairs are small enough to stay inline.

Test Plan:
1. Reset, then Start with NUM_WORDS=2; send bytes 0x12, 0x34, 0x56, 0x78 over UART (SIMULATION rate, 6 clocks/bit) -> SRAM writes 0x1234 @ 0 and 0x5678 @ 1, one Done pulse, both counters 0.
2. Single byte: send 0xAB -> exactly one RX_unload pulse and no SRAM write; after 0xCD, one write of 0xABCD.
3. Send 0x11, then a byte with stop bit 0, then 0x22 -> Frame_error_count=1, write 0x1122, corrupt byte absent.
4. Hold RX_empty low for 3 cycles with RX_data constant (stub receiver that honours the unload latency) -> only one unload per byte, no duplicate bytes.
5. Assert Resetn=0 after 3 of 4 bytes, release, Start, send 4 new bytes -> writes begin at BASE_ADDR and contain only the new data.
6. Pulse Start during S_WAIT_BYTE; BASE_ADDR=18'h3FFFF with NUM_WORDS=2 -> Start ignored; writes go to 3FFFF then 00000, and Done is asserted once.
